// File: rtl/sar_search.sv
// sar_search: successive-approximation search engine driving a magnitude
// comparator's `b` operand. It walks one bit per probe from the MSB down and
// resolves the externally held target in at most WIDTH probes.
`timescale 1ns/1ps

module sar_search #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gt_in,
  input  logic             lt_in,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  // Bit-index width; at least one bit so WIDTH=1 still elaborates.
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [WIDTH-1:0]   guess_q, guess_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               err_q,   err_d;

  // Mask of the bit under test and of the next lower bit to try.
  logic [WIDTH-1:0]   cur_mask;
  logic [WIDTH-1:0]   nxt_mask;
  logic [WIDTH-1:0]   cleared;
  logic               idx_zero;

  // Per-probe masks derived from the current bit index.
  always_comb begin
    cur_mask = WIDTH'(1) << idx_q;
    nxt_mask = WIDTH'(1) << (idx_q - IDX_W'(1));
    cleared  = guess_q & ~cur_mask;
    idx_zero = (idx_q == IDX_W'(0));
  end

  // Next-state and next-output logic; every terminating branch parks guess at 0.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    guess_d  = guess_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        guess_d = '0;
        busy_d  = 1'b0;
        if (start) begin
          state_d  = ST_PROBE;
          idx_d    = IDX_W'(WIDTH - 1);
          guess_d  = WIDTH'(1) << (WIDTH - 1);
          result_d = '0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end

      ST_PROBE: begin
        if (gt_in && lt_in) begin
          // Comparator claims both greater and less: flag and stop.
          err_d    = 1'b1;
          result_d = guess_q;
          state_d  = ST_DONE;
        end else if (!gt_in && !lt_in) begin
          // Exact hit: no need to refine the remaining bits.
          result_d = guess_q;
          state_d  = ST_DONE;
        end else if (lt_in) begin
          // Guess too high: drop the bit under test.
          if (idx_zero) begin
            result_d = cleared;
            state_d  = ST_DONE;
          end else begin
            guess_d = cleared | nxt_mask;
            idx_d   = idx_q - IDX_W'(1);
          end
        end else begin
          // Guess too low: keep the bit; at the LSB this cannot be consistent.
          if (idx_zero) begin
            err_d    = 1'b1;
            result_d = guess_q;
            state_d  = ST_DONE;
          end else begin
            guess_d = guess_q | nxt_mask;
            idx_d   = idx_q - IDX_W'(1);
          end
        end

        if (state_d == ST_DONE) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          guess_d = '0;
        end
      end

      ST_DONE: begin
        // Single-cycle completion pulse; start is ignored here.
        state_d = ST_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        guess_d = '0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        guess_d = '0;
      end
    endcase
  end

  // State and registered outputs; async reset aborts any search silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      guess_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed self-checking bench for sar_search (WIDTH=4) with a behavioural
// comparator that can be forced into inconsistent modes.
`timescale 1ns/1ps

module tb_sar_search;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       gt_in;
  logic       lt_in;
  logic [3:0] guess;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       err;

  logic [3:0] target;
  int         cmp_mode;   // 0 real comparator, 1 both asserted, 2 gt stuck high

  int n_cmp;
  int n_err;

  logic [3:0] glog [8];
  int         np;
  int         cyc;

  sar_search #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .gt_in (gt_in),
    .lt_in (lt_in),
    .guess (guess),
    .busy  (busy),
    .done  (done),
    .result(result),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural comparator: a = target, b = guess.
  always_comb begin
    gt_in = 1'b0;
    lt_in = 1'b0;
    case (cmp_mode)
      1: begin gt_in = 1'b1; lt_in = 1'b1; end
      2: begin gt_in = 1'b1; lt_in = 1'b0; end
      default: begin gt_in = (target > guess); lt_in = (target < guess); end
    endcase
  end

  // Pulse start for one edge, then log guesses until done (bounded).
  // cyc counts edges from start acceptance to the edge that raised done.
  task automatic run_search(input logic [3:0] tgt);
    target = tgt;
    np = 0;
    for (int i = 0; i < 8; i++) glog[i] = 4'hx;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    while (!done && cyc < 12) begin
      if (busy && np < 8) begin glog[np] = guess; np++; end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; target = 4'd0; cmp_mode = 0;
    #1;
    n_cmp++;
    if ({guess, busy, done, result, err} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got guess=%0d busy=%b done=%b result=%0d err=%b, want all 0",
               guess, busy, done, result, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({guess, busy, done} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_idle: got guess=%0d busy=%b done=%b, want 0/0/0", guess, busy, done);
    end
  endtask

  task automatic test_target5();
    logic [3:0] exp [4] = '{4'd8, 4'd4, 4'd6, 4'd5};
    run_search(4'd5);
    n_cmp++;
    if (np !== 4) begin n_err++; $display("FAIL t5_probes: got %0d want 4", np); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (glog[i] !== exp[i]) begin
        n_err++; $display("FAIL t5_guess[%0d]: got %0d want %0d", i, glog[i], exp[i]);
      end
    end
    n_cmp++;
    if (done !== 1'b1 || cyc !== 5) begin
      n_err++; $display("FAIL t5_latency: done=%b cyc=%0d, want done=1 cyc=5", done, cyc);
    end
    n_cmp++;
    if (result !== 4'd5 || err !== 1'b0 || busy !== 1'b0 || guess !== 4'd0) begin
      n_err++;
      $display("FAIL t5_result: result=%0d err=%b busy=%b guess=%0d, want 5/0/0/0",
               result, err, busy, guess);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 4'd5) begin
      n_err++; $display("FAIL t5_pulse: done=%b busy=%b result=%0d, want 0/0/5", done, busy, result);
    end
  endtask

  task automatic test_equal_first();
    run_search(4'd8);
    n_cmp++;
    if (done !== 1'b1 || cyc !== 2 || np !== 1 || glog[0] !== 4'd8) begin
      n_err++;
      $display("FAIL t8_latency: done=%b cyc=%0d probes=%0d g0=%0d, want 1/2/1/8",
               done, cyc, np, glog[0]);
    end
    n_cmp++;
    if (result !== 4'd8 || err !== 1'b0) begin
      n_err++; $display("FAIL t8_result: result=%0d err=%b, want 8/0", result, err);
    end
  endtask

  task automatic test_bounds();
    logic [3:0] exp0  [4] = '{4'd8, 4'd4, 4'd2, 4'd1};
    logic [3:0] exp15 [4] = '{4'd8, 4'd12, 4'd14, 4'd15};
    run_search(4'd0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (glog[i] !== exp0[i]) begin
        n_err++; $display("FAIL t0_guess[%0d]: got %0d want %0d", i, glog[i], exp0[i]);
      end
    end
    n_cmp++;
    if (done !== 1'b1 || cyc !== 5 || result !== 4'd0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL t0_result: done=%b cyc=%0d result=%0d err=%b, want 1/5/0/0", done, cyc, result, err);
    end
    run_search(4'd15);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (glog[i] !== exp15[i]) begin
        n_err++; $display("FAIL t15_guess[%0d]: got %0d want %0d", i, glog[i], exp15[i]);
      end
    end
    n_cmp++;
    if (done !== 1'b1 || cyc !== 5 || result !== 4'd15 || err !== 1'b0) begin
      n_err++;
      $display("FAIL t15_result: done=%b cyc=%0d result=%0d err=%b, want 1/5/15/0", done, cyc, result, err);
    end
  endtask

  task automatic test_errors();
    logic [3:0] expg [4] = '{4'd8, 4'd12, 4'd14, 4'd15};
    cmp_mode = 1;
    run_search(4'd3);
    n_cmp++;
    if (done !== 1'b1 || cyc !== 2 || err !== 1'b1 || result !== 4'd8) begin
      n_err++;
      $display("FAIL both_err: done=%b cyc=%0d err=%b result=%0d, want 1/2/1/8", done, cyc, err, result);
    end
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1 || result !== 4'd8) begin
      n_err++; $display("FAIL both_hold: err=%b result=%0d, want 1/8", err, result);
    end
    cmp_mode = 2;
    run_search(4'd3);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (glog[i] !== expg[i]) begin
        n_err++; $display("FAIL gtstuck_guess[%0d]: got %0d want %0d", i, glog[i], expg[i]);
      end
    end
    n_cmp++;
    if (done !== 1'b1 || cyc !== 5 || err !== 1'b1 || result !== 4'd15) begin
      n_err++;
      $display("FAIL gtstuck_err: done=%b cyc=%0d err=%b result=%0d, want 1/5/1/15", done, cyc, err, result);
    end
    cmp_mode = 0;
    // err must clear once the next search is accepted.
    run_search(4'd6);
    n_cmp++;
    if (err !== 1'b0 || result !== 4'd6) begin
      n_err++; $display("FAIL err_clear: err=%b result=%0d, want 0/6", err, result);
    end
  endtask

  task automatic test_async_reset();
    int n;
    target = 4'd13;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (guess !== 4'd12 && n < 8) begin @(negedge clk); n++; end
    n_cmp++;
    if (guess !== 4'd12 || busy !== 1'b1) begin
      n_err++; $display("FAIL rst_reach12: guess=%0d busy=%b, want 12/1", guess, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({guess, busy, done, result, err} !== 11'd0) begin
      n_err++;
      $display("FAIL rst_async: guess=%0d busy=%b done=%b result=%0d err=%b, want all 0",
               guess, busy, done, result, err);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL rst_stale[%0d]: done=%b busy=%b, want 0/0", i, done, busy);
      end
    end
    run_search(4'd3);
    n_cmp++;
    if (done !== 1'b1 || result !== 4'd3 || err !== 1'b0 || np !== 4) begin
      n_err++;
      $display("FAIL rst_after: done=%b result=%0d err=%b probes=%0d, want 1/3/0/4", done, result, err, np);
    end
  endtask

  // Start held high throughout: each search must wait for IDLE before restarting.
  task automatic test_back_to_back();
    int n;
    int probes;
    target = 4'd0;
    @(negedge clk); start = 1'b1;
    for (int t = 0; t < 16; t++) begin
      probes = 0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n == 1) begin
          n_cmp++;
          if (busy !== 1'b1 || guess !== 4'd8) begin
            n_err++; $display("FAIL b2b_first[%0d]: busy=%b guess=%0d, want 1/8", t, busy, guess);
          end
        end
        if (busy) probes++;
      end while (!done && n < 12);
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || result !== 4'(t) || err !== 1'b0 ||
          probes < 1 || probes > 4) begin
        n_err++;
        $display("FAIL b2b_result[%0d]: done=%b busy=%b result=%0d err=%b probes=%0d, want done=1 busy=0 result=%0d err=0 probes 1..4",
                 t, done, busy, result, err, probes, t);
      end
      if (t < 15) target = 4'(t + 1);
      else start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || guess !== 4'd0 || result !== 4'(t)) begin
        n_err++;
        $display("FAIL b2b_idle[%0d]: busy=%b done=%b guess=%0d result=%0d, want 0/0/0/%0d",
                 t, busy, done, guess, result, t);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL b2b_end: busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_target5();
    test_equal_first();
    test_bounds();
    test_errors();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Sequential successive-approximation search engine that drives the probe operand into a magnitude comparator and consumes its GT/LT outputs.
- The comparator's `a` input carries an externally held target value. This block drives `b` with trial guesses and resolves the target in at most WIDTH probe cycles.
- Sits on the initiator side of the comparator interface. Used for threshold discovery and as a self-checking driver for the comparator.

Parameters:
- WIDTH, 4, operand width in bits; must be >= 1. Equals the maximum number of probe cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new search; sampled only in IDLE
- gt_in  input  1  comparator GT: target > guess
- lt_in  input  1  comparator LT: target < guess
- guess  output  WIDTH  probe value driven to comparator `b`
- busy  output  1  high while in PROBE
- done  output  1  one-cycle pulse when a search completes
- result  output  WIDTH  resolved target; held until the next start is accepted
- err  output  1  comparator inconsistency detected; valid with done, held with result

Behaviour:
- Reset is asynchronous active-low. While rst_n=0: state=IDLE, guess=0, busy=0, done=0, result=0, err=0, idx=0. Reset mid-search aborts the search with no done pulse.
- The comparator is combinational. gt_in/lt_in are sampled on the same edge that ends the cycle in which `guess` is stable.
- States:
  - IDLE
    - guess=0, busy=0.
    - start=1 at an edge: state<=PROBE, idx<=WIDTH-1, guess<=1<<(WIDTH-1), result<=0, err<=0, busy<=1.
    - start=0: remain in IDLE.
  - PROBE, one decision per edge, priority order:
    - 1. gt_in=1 and lt_in=1: err<=1, result<=guess, go to DONE.
    - 2. gt_in=0 and lt_in=0 (equal): result<=guess, go to DONE (early exit).
    - 3. lt_in=1: clear bit idx of guess.
      - If idx=0: result<=guess with bit0 cleared, go to DONE.
      - Else: guess<=(guess with bit idx cleared) | (1<<(idx-1)), idx<=idx-1.
    - 4. gt_in=1: keep bit idx.
      - If idx=0: impossible for a consistent comparator; err<=1, result<=guess, go to DONE.
      - Else: guess<=guess | (1<<(idx-1)), idx<=idx-1.
  - Go to DONE means: state<=DONE, done<=1, busy<=0, guess<=0.
  - DONE
    - done=1 for exactly this cycle.
    - Next edge: done<=0, state<=IDLE.
    - start is ignored in DONE.
- start while busy or in DONE is ignored; it is not queued.
- Latency: the first probe is visible the cycle after start is accepted. done rises 1..WIDTH edges after the first probe edge, plus 1 (from the start-acceptance edge: min 2, max WIDTH+1).
- Minimum start-to-start spacing is 3 cycles (accept, ≥1 probe, DONE).
- result and err are stable from the done pulse until the next accepted start.
- The target must stay constant while busy=1. If it changes, the result is undefined but the FSM must still terminate within WIDTH probes.
- Exactly one of busy, done, or idle holds at any time.

Test Plan:
- target=5, pulse start -> guesses 8,4,6,5 on consecutive cycles; done after 4th probe; result=5, err=0.
- target=8 -> single probe guess=8 equal; done on next cycle; result=8; total 2 cycles from start acceptance.
- target=0 -> guesses 8,4,2,1 all LT; result=0, err=0. target=15 -> guesses 8,12,14,15; result=15 via equal early exit.
- Force gt_in=lt_in=1 on first probe -> done next cycle, err=1, result=8. Force gt_in=1 always -> guesses 8,12,14,15, then err=1 at idx=0, result=15.
- Deassert rst_n mid-search after guess=12 -> all outputs 0 immediately (async). Release reset, start with target=3 -> result=3, no stale done.
- Exhaustive sweep: target 0..15 against the real comparator, back-to-back starts, start also held high through busy/DONE -> every result equals target, err=0, ≤4 probes each, held start accepted only in IDLE.
